// File: rtl/gpu_pkg.sv
// Shared encodings for the fetch path: arbiter sequencing states and fetcher core states,
// plus the index-width helper used wherever a consumer index is carried.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RELAY = 2'b10
  } arb_state_e;

  typedef enum logic [2:0] {
    FETCH  = 3'b001,
    DECODE = 3'b010
  } core_state_e;

  // A single consumer still needs a 1-bit index.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_arbiter_rr_picker.sv
// Wrap-around priority scan: first asserted request at or above ptr_i, wrapping
// from NUM_CONSUMERS-1 back to 0.
module rr_picker import gpu_pkg::*; #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned IDX_BITS      = idx_bits(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] req_i,
  input  logic [IDX_BITS-1:0]      ptr_i,
  output logic                     found_o,
  output logic [IDX_BITS-1:0]      idx_o
);

  logic [2*NUM_CONSUMERS-1:0] req_dup;
  logic [NUM_CONSUMERS-1:0]   rot;

  // Rotating the doubled vector puts ptr_i at bit 0, so a plain LSB-first scan is the wrap scan.
  assign req_dup = {req_i, req_i};
  assign rot     = NUM_CONSUMERS'(req_dup >> ptr_i);

  always_comb begin
    int unsigned sum;
    sum     = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
      if (!found_o && rot[k]) begin
        found_o = 1'b1;
        sum     = int'(ptr_i) + k;
        if (sum >= NUM_CONSUMERS) sum = sum - NUM_CONSUMERS;
        idx_o   = IDX_BITS'(sum);
      end
    end
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin sharing of the program-memory read channel among per-core fetchers;
// a grant is held from issue through response relay until the fetcher releases valid.
module fetch_arbiter import gpu_pkg::*; #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16,
  localparam int unsigned GID_BITS     = idx_bits(NUM_CONSUMERS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  output logic                                     mem_read_valid,
  input  logic                                     mem_read_ready,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     busy,
  output logic [GID_BITS-1:0]                      grant_id
);

  localparam logic [GID_BITS-1:0] LAST_IDX = GID_BITS'(NUM_CONSUMERS - 1);

  arb_state_e                               state_q;
  logic [GID_BITS-1:0]                      rr_ptr_q;
  logic [GID_BITS-1:0]                      grant_q;
  logic                                     mem_valid_q;
  logic [ADDR_BITS-1:0]                     mem_addr_q;
  logic [NUM_CONSUMERS-1:0]                 ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  data_q;
  logic                                     busy_q;

  logic                                     pick_found;
  logic [GID_BITS-1:0]                      pick_idx;

  rr_picker #(
    .NUM_CONSUMERS(NUM_CONSUMERS),
    .IDX_BITS     (GID_BITS)
  ) u_picker (
    .req_i  (consumer_read_valid),
    .ptr_i  (rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q     <= pick_idx;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= consumer_read_address[pick_idx];
            rr_ptr_q    <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_read_ready) begin
            mem_valid_q      <= 1'b0;
            data_q[grant_q]  <= mem_read_data;
            ready_q[grant_q] <= 1'b1;
            state_q          <= RELAY;
          end
        end
        RELAY: begin
          // Waiting for valid to drop keeps a still-high stale request from being re-granted.
          ready_q <= '0;
          if (!consumer_read_valid[grant_q]) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          ready_q     <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = data_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;
  assign busy                = busy_q;
  assign grant_id            = grant_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: expected memory requests and fetcher responses are
// queued by the stimulus and checked by independent monitors as the DUT presents them.
module tb_fetch_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      cv;
  logic [N-1:0][7:0] caddr;
  logic [N-1:0]      cready;
  logic [N-1:0][15:0] cdata;
  logic              mem_read_valid;
  logic              mem_read_ready;
  logic [7:0]        mem_read_address;
  logic [15:0]       mem_read_data;
  logic              busy;
  logic [1:0]        grant_id;

  fetch_arbiter #(
    .NUM_CONSUMERS(N),
    .ADDR_BITS    (8),
    .DATA_BITS    (16)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .consumer_read_valid  (cv),
    .consumer_read_address(caddr),
    .consumer_read_ready  (cready),
    .consumer_read_data   (cdata),
    .mem_read_valid       (mem_read_valid),
    .mem_read_ready       (mem_read_ready),
    .mem_read_address     (mem_read_address),
    .mem_read_data        (mem_read_data),
    .busy                 (busy),
    .grant_id             (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; int gid; } mem_exp_t;
  typedef struct { int idx; logic [15:0] data; } rsp_exp_t;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];

  int checks = 0;
  int passes = 0;

  logic [15:0] mem_tbl [256];
  int          mem_lat  = 1;
  bit          mem_auto = 1'b1;
  int          remaining [N];
  bit          withdraw  [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory model: answers each request after mem_lat cycles with a one-cycle strobe.
  initial begin
    int cnt;
    cnt = 0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        if (mem_read_valid && !mem_read_ready) begin
          cnt++;
          if (cnt >= mem_lat) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem_tbl[mem_read_address];
            cnt = 0;
          end
        end else begin
          mem_read_ready = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // Fetcher model: raises valid while requests remain, drops it the cycle after ready.
  initial begin
    cv = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (withdraw[i]) begin
          cv[i] = 1'b0;
          remaining[i] = 0;
          withdraw[i] = 1'b0;
        end else if (cready[i]) begin
          cv[i] = 1'b0;
          if (remaining[i] > 0) remaining[i]--;
        end else if (remaining[i] > 0) begin
          cv[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: memory requests (on rising valid) and response pulses.
  initial begin
    logic     prev_v;
    logic [N-1:0] prev_r;
    mem_exp_t me;
    rsp_exp_t re;
    int       idx;
    prev_v = 1'b0;
    prev_r = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_read_valid && !prev_v) begin
        if (exp_mem.size() == 0) begin
          chk("mem_req_spurious", 32'(mem_read_address), 32'hFFFF_FFFF);
        end else begin
          me = exp_mem.pop_front();
          chk("mem_req_addr", 32'(mem_read_address), 32'(me.addr));
          chk("mem_req_gid", 32'(grant_id), 32'(me.gid));
        end
      end
      if (cready != '0) begin
        chk("rsp_onehot", 32'($countones(cready)), 32'd1);
        if (prev_r != '0) chk("rsp_pulse_width", 32'(prev_r), 32'd0);
        idx = 0;
        for (int i = 0; i < N; i++) if (cready[i]) idx = i;
        if (exp_rsp.size() == 0) begin
          chk("rsp_spurious", 32'(cready), 32'd0);
        end else begin
          re = exp_rsp.pop_front();
          chk("rsp_idx", 32'(idx), 32'(re.idx));
          chk("rsp_data", 32'(cdata[idx]), 32'(re.data));
        end
      end
      prev_v = mem_read_valid;
      prev_r = cready;
    end
  end

  task automatic push_txn(input int idx, input logic [7:0] addr, input logic [15:0] data);
    mem_exp_t me;
    rsp_exp_t re;
    me.addr = addr; me.gid = idx;
    re.idx  = idx;  re.data = data;
    exp_mem.push_back(me);
    exp_rsp.push_back(re);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      done = (exp_mem.size() == 0) && (exp_rsp.size() == 0) && !busy && (cv == '0)
             && (remaining[0] == 0) && (remaining[1] == 0) && (remaining[2] == 0) && (remaining[3] == 0);
    end
    checks++;
    if (done) passes++;
    else $display("FAIL %s_timeout: busy=%0b mem_q=%0d rsp_q=%0d, required idle with empty queues",
                  name, busy, exp_mem.size(), exp_rsp.size());
  endtask

  task automatic wait_ready(input string name, input int idx);
    for (int k = 0; k < 100 && !cready[idx]; k++) step();
    chk(name, 32'(cready[idx]), 32'd1);
  endtask

  task automatic do_reset;
    #1 reset = 1'b1;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_read_address), 32'd0);
    chk("rst_ready", 32'(cready), 32'd0);
    chk("rst_data", 32'(cdata[0] | cdata[1] | cdata[2] | cdata[3]), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    caddr = '0;
    for (int i = 0; i < 256; i++) mem_tbl[i] = 16'h0;
    for (int i = 0; i < N; i++) begin remaining[i] = 0; withdraw[i] = 1'b0; end
    mem_tbl[8'h15] = 16'hABCD;
    mem_tbl[8'h10] = 16'h1000; mem_tbl[8'h11] = 16'h1111;
    mem_tbl[8'h12] = 16'h2222; mem_tbl[8'h13] = 16'h3333;
    mem_tbl[8'h31] = 16'h0131; mem_tbl[8'h32] = 16'h0232;
    mem_tbl[8'h40] = 16'h0440; mem_tbl[8'h43] = 16'h0443;
    mem_tbl[8'h33] = 16'h3C3C; mem_tbl[8'h30] = 16'h0C0C;
    mem_tbl[8'h21] = 16'h5A5A;
    mem_tbl[8'h61] = 16'h6161; mem_tbl[8'h63] = 16'h6363;
    step();
    do_reset();

    // Single request, 3-cycle memory.
    mem_lat = 3;
    push_txn(2, 8'h15, 16'hABCD);
    #1 caddr[2] = 8'h15; remaining[2] = 1;
    step();
    chk("t1_latency_valid", 32'(mem_read_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1");
    chk("t1_data_held", 32'(cdata[2]), 32'hABCD);

    // Sparse wrap: pointer sits at 3, consumers 1 and 2 request.
    mem_lat = 1;
    push_txn(1, 8'h31, 16'h0131);
    push_txn(2, 8'h32, 16'h0232);
    #1 caddr[1] = 8'h31; caddr[2] = 8'h32; remaining[1] = 1; remaining[2] = 1;
    wait_done("t3");
    // Pointer now back at 3: consumer 3 must beat consumer 0.
    push_txn(3, 8'h43, 16'h0443);
    push_txn(0, 8'h40, 16'h0440);
    #1 caddr[0] = 8'h40; caddr[3] = 8'h43; remaining[0] = 1; remaining[3] = 1;
    wait_done("t3b");
    chk("t3b_other_held", 32'(cdata[1]), 32'h0131);

    // Round robin from a fresh pointer with everyone requesting.
    do_reset();
    push_txn(0, 8'h10, 16'h1000);
    push_txn(1, 8'h11, 16'h1111);
    push_txn(2, 8'h12, 16'h2222);
    push_txn(3, 8'h13, 16'h3333);
    push_txn(0, 8'h10, 16'h1000);
    #1 for (int i = 0; i < N; i++) caddr[i] = 8'(8'h10 + i);
    remaining[0] = 2; remaining[1] = 1; remaining[2] = 1; remaining[3] = 1;
    wait_done("t2");

    // Consumer 0 arrives during consumer 3's ISSUE.
    mem_lat = 4;
    push_txn(3, 8'h33, 16'h3C3C);
    push_txn(0, 8'h30, 16'h0C0C);
    #1 caddr[3] = 8'h33; remaining[3] = 1;
    step();
    #1 caddr[0] = 8'h30; remaining[0] = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t4_issue_valid_held", 32'(mem_read_valid), 32'd1);
      chk("t4_issue_grant_held", 32'(grant_id), 32'd3);
    end
    wait_ready("t4_ready3_seen", 3);
    step();
    chk("t4_idle_after_relay", 32'(busy), 32'd0);
    step();
    chk("t4_next_valid", 32'(mem_read_valid), 32'd1);
    chk("t4_next_grant", 32'(grant_id), 32'd0);
    wait_done("t4");

    // Early withdraw in ISSUE.
    mem_lat = 3;
    push_txn(1, 8'h21, 16'h5A5A);
    #1 caddr[1] = 8'h21; remaining[1] = 1;
    step();
    chk("t5_valid", 32'(mem_read_valid), 32'd1);
    #1 withdraw[1] = 1'b1;
    wait_ready("t5_ready_seen", 1);
    step();
    chk("t5_relay_one_cycle", 32'(busy), 32'd0);
    chk("t5_data", 32'(cdata[1]), 32'h5A5A);
    wait_done("t5");

    // Reset in the middle of ISSUE, then a late memory strobe.
    mem_auto = 1'b0;
    begin
      mem_exp_t me;
      me.addr = 8'h42; me.gid = 2;
      exp_mem.push_back(me);
    end
    #1 caddr[2] = 8'h42; remaining[2] = 1;
    step();
    chk("t6_valid", 32'(mem_read_valid), 32'd1);
    #1 reset = 1'b1; withdraw[2] = 1'b1;
    step();
    chk("t6_rst_valid", 32'(mem_read_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_grant", 32'(grant_id), 32'd0);
    #1 reset = 1'b0; mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    step();
    chk("t6_late_busy", 32'(busy), 32'd0);
    chk("t6_late_data", 32'(cdata[2]), 32'd0);
    chk("t6_late_ready", 32'(cready), 32'd0);
    #1 mem_read_ready = 1'b0; mem_auto = 1'b1; mem_lat = 1;
    // Pointer is back at 0: consumer 1 precedes consumer 3.
    push_txn(1, 8'h61, 16'h6161);
    push_txn(3, 8'h63, 16'h6363);
    caddr[1] = 8'h61; caddr[3] = 8'h63; remaining[1] = 1; remaining[3] = 1;
    wait_done("t6");

    chk("final_mem_q_empty", 32'(exp_mem.size()), 32'd0);
    chk("final_rsp_q_empty", 32'(exp_rsp.size()), 32'd0);
    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_arbiter.md
Name: fetch_arbiter

Overview:
Shares one program-memory read channel among NUM_CONSUMERS per-core instruction fetchers using round-robin arbitration. It sits between the fetchers' valid/ready read interfaces and the program memory read port. Each grant is held for the whole transaction: issue, memory response, relay to the fetcher, and release.

Parameters:
NUM_CONSUMERS, 4, number of fetchers sharing the channel (>=1, any value, not only powers of two)
ADDR_BITS, 8, program memory address width
DATA_BITS, 16, instruction width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request, held high until served
consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  per-fetcher address, stable while valid
consumer_read_ready  out  NUM_CONSUMERS  one-cycle response pulse per fetcher
consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  per-fetcher instruction, held until overwritten
mem_read_valid  out  1  request to program memory
mem_read_address  out  ADDR_BITS  address to program memory
mem_read_ready  in  1  memory response strobe
mem_read_data  in  DATA_BITS  memory response data
busy  out  1  high in any state other than IDLE
grant_id  out  clog2(NUM_CONSUMERS), min 1  index of the consumer being served; valid while busy

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, grant_id=0, mem_read_valid=0, mem_read_address=0, all consumer_read_ready=0, all consumer_read_data=0.
- Reset mid-transaction aborts it. The memory sees mem_read_valid drop; no ready pulse is sent to the consumer.
- All outputs are registered.
- States are IDLE, ISSUE, RELAY.
- IDLE:
  - If any consumer_read_valid is high, pick the first asserted index scanning from rr_ptr upward, wrapping at NUM_CONSUMERS-1 -> 0.
  - On that pick: grant_id<=g, mem_read_valid<=1, mem_read_address<=consumer_read_address[g], rr_ptr<=(g==NUM_CONSUMERS-1)?0:g+1, state<=ISSUE.
  - Latency from request to mem_read_valid is 1 cycle.
- ISSUE:
  - Hold mem_read_valid and mem_read_address.
  - On mem_read_ready: mem_read_valid<=0, consumer_read_data[grant_id]<=mem_read_data, consumer_read_ready[grant_id]<=1, state<=RELAY.
  - Memory latency is unbounded; wait indefinitely.
- RELAY:
  - consumer_read_ready<=0, so the pulse is exactly one cycle.
  - If consumer_read_valid[grant_id] is low, go to IDLE. Otherwise stay in RELAY until it drops.
  - This prevents a stale still-high valid from being re-granted.
  - A compliant fetcher drops valid the cycle after it sees ready, so the minimum RELAY dwell is 1 cycle.
- Minimum transaction length: 1 (IDLE) + 1+memory latency (ISSUE) + 1 (RELAY) cycles.
- Requests are sampled only in IDLE. Requests arriving mid-transaction wait; there is no loss and no queue.
- If a granted consumer drops valid before the response, the transaction still completes. Data and the ready pulse are delivered and ignored; RELAY exits next cycle.
- mem_read_ready in IDLE or RELAY is ignored.
- Only the granted index's consumer_read_data changes. Other entries hold.
- With NUM_CONSUMERS=1, grant is always 0 and rr_ptr stays 0.
- Fairness: with all consumers requesting continuously, grants cycle 0,1,...,N-1,0. Each consumer waits at most N-1 transactions.

Decomposition:
- Shared package gpu_pkg: arbiter state encodings (IDLE=2'b00, ISSUE=2'b01, RELAY=2'b10); fetcher core-state encodings FETCH=3'b001, DECODE=3'b010 for reuse.
- One combinational sub-module rr_picker:
  - Inputs: request vector and rr_ptr.
  - Outputs: found flag and index.
  - Implemented as a wrap-around priority scan.
- All sequencing stays in fetch_arbiter.

Test Plan:
- Single request: consumer 2 requests addr 0x15; memory answers 0xABCD after 3 cycles.
  - mem_read_valid rises 1 cycle after request, address 0x15.
  - consumer_read_ready[2] pulses once, data[2]=0xABCD.
  - busy falls after valid drops.
- Round-robin: all 4 request continuously, memory latency 1.
  - Grant order 0,1,2,3,0.
  - Each ready pulse goes to the matching index with the data for its address.
- Wrap with sparse requests: rr_ptr=3, requests from 1 and 2.
  - Grant 1 first, then 2, then rr_ptr=3.
- Simultaneous event: consumer 0 asserts valid during consumer 3's ISSUE.
  - No mem_read_valid glitch.
  - Consumer 0 is served immediately after consumer 3's RELAY->IDLE.
- Early withdraw: granted consumer drops valid in ISSUE.
  - Response is still captured and the ready pulse is issued.
  - RELAY lasts 1 cycle, then IDLE.
- Reset mid-ISSUE: next cycle mem_read_valid=0, busy=0, rr_ptr=0.
  - No consumer_read_ready pulse.
  - A late mem_read_ready is ignored.
